stream_protocol_monitor: RTL and testbench



---
 rtl/stream_monitor_pkg.sv | 14 +
 rtl/sat_counter.sv | 28 ++
 rtl/stream_protocol_monitor.sv | 175 +++++++++++++++++
 tb/tb_stream_protocol_monitor.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_monitor_pkg.sv
// Shared definitions for the ready/valid stream protocol monitor.
// Holds the beat-tracking FSM state encoding used by stream_protocol_monitor.
package stream_monitor_pkg;

   // IDLE    : no outstanding beat
   // PENDING : valid was seen without ready and is still outstanding
   // HUNG    : PENDING for at least TimeoutCycles consecutive stall cycles
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PENDING = 2'd1,
      HUNG    = 2'd2
   } mon_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset, counter to 0
//   clr_i  - synchronous clear, wins over a same-cycle increment
//   inc_i  - increment request; ignored once the count is all-ones
//   cnt_o  - current count
module sat_counter #(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [WIDTH-1:0] cnt_o
);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_o <= '0;
      end else if (clr_i) begin
         cnt_o <= '0;
      end else if (inc_i && (cnt_o != '1)) begin
         cnt_o <= cnt_o + WIDTH'(1);
      end
   end

endmodule

// File: rtl/stream_protocol_monitor.sv
// Passive observer for one ready/valid stream. Drives nothing on the stream.
//
// Handshake semantics observed: a beat transfers in any cycle where
// valid_i & ready_i. Once valid_i is raised it must stay high, with data_i
// unchanged, until the transfer cycle; a valid drop before transfer is a
// drop error, a payload change while outstanding is a change error.
//
// Ports:
//   clk_i, rst_i   - clock, asynchronous active-high reset
//   valid_i, ready_i, data_i - monitored stream taps
//   clear_i        - synchronous clear of counters, last_vld_o and err_* flags
//   xfer_cnt_o     - saturating count of handshakes
//   stall_cnt_o    - saturating count of valid & !ready cycles
//   last_data_o    - payload of the most recent handshake
//   last_vld_o     - at least one handshake since reset/clear
//   hung_o         - FSM currently in HUNG (non-sticky)
//   err_drop_o     - sticky: valid dropped before acceptance
//   err_change_o   - sticky: payload changed while a beat was outstanding
//   err_timeout_o  - sticky: HUNG was entered
module stream_protocol_monitor
   import stream_monitor_pkg::*;
#(
   parameter type T             = logic,
   parameter int  CntWidth      = 32,
   parameter int  TimeoutCycles = 1024
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                valid_i,
   input  logic                ready_i,
   input  logic [$bits(T)-1:0] data_i,
   input  logic                clear_i,
   output logic [CntWidth-1:0] xfer_cnt_o,
   output logic [CntWidth-1:0] stall_cnt_o,
   output logic [$bits(T)-1:0] last_data_o,
   output logic                last_vld_o,
   output logic                hung_o,
   output logic                err_drop_o,
   output logic                err_change_o,
   output logic                err_timeout_o
);

   localparam int DataWidth = $bits(T);
   // Wide enough to hold TimeoutCycles; at least one bit when timeouts are off.
   localparam int RunWidth  = ($clog2(TimeoutCycles + 1) < 1) ? 1 : $clog2(TimeoutCycles + 1);

   mon_state_e             state_q, state_d;
   logic [DataWidth-1:0]   pend_q;
   logic [RunWidth-1:0]    run_cnt;

   logic handshake, stall;
   logic capture, run_inc, run_clr;
   logic drop_evt, change_evt, timeout_evt;

   assign handshake = valid_i & ready_i;
   assign stall     = valid_i & ~ready_i;

   // Next-state and event decode.
   always_comb begin
      state_d     = state_q;
      capture     = 1'b0;
      run_inc     = 1'b0;
      run_clr     = 1'b0;
      drop_evt    = 1'b0;
      change_evt  = 1'b0;
      timeout_evt = 1'b0;
      case (state_q)
         IDLE: begin
            if (stall) begin
               capture = 1'b1;
               run_inc = 1'b1;   // run counter is 0 in IDLE, so this makes it 1
               // A single-cycle timeout is already reached by this first stall.
               if (TimeoutCycles == 1) begin
                  state_d     = HUNG;
                  timeout_evt = 1'b1;
               end else begin
                  state_d = PENDING;
               end
            end
         end
         PENDING, HUNG: begin
            if (!valid_i) begin
               drop_evt = 1'b1;
               run_clr  = 1'b1;
               state_d  = IDLE;
            end else begin
               // Pending register is not refreshed, so a lasting change
               // keeps flagging every cycle.
               if (data_i != pend_q) begin
                  change_evt = 1'b1;
               end
               if (ready_i) begin
                  run_clr = 1'b1;
                  state_d = IDLE;
               end else begin
                  run_inc = 1'b1;
                  if ((state_q == PENDING) && (TimeoutCycles != 0) &&
                      ((int'(run_cnt) + 1) >= TimeoutCycles)) begin
                     state_d     = HUNG;
                     timeout_evt = 1'b1;
                  end
               end
            end
         end
         default: begin
            state_d = IDLE;
            run_clr = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         pend_q  <= '0;
      end else begin
         state_q <= state_d;
         if (capture) begin
            pend_q <= data_i;
         end
      end
   end

   // Sticky flags and last-beat capture; clear beats any same-cycle event.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         err_drop_o    <= 1'b0;
         err_change_o  <= 1'b0;
         err_timeout_o <= 1'b0;
         last_vld_o    <= 1'b0;
         last_data_o   <= '0;
      end else if (clear_i) begin
         err_drop_o    <= 1'b0;
         err_change_o  <= 1'b0;
         err_timeout_o <= 1'b0;
         last_vld_o    <= 1'b0;
      end else begin
         if (drop_evt)    err_drop_o    <= 1'b1;
         if (change_evt)  err_change_o  <= 1'b1;
         if (timeout_evt) err_timeout_o <= 1'b1;
         if (handshake) begin
            last_vld_o  <= 1'b1;
            last_data_o <= data_i;
         end
      end
   end

   assign hung_o = (state_q == HUNG);

   sat_counter #(.WIDTH(CntWidth)) u_xfer_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .inc_i (handshake),
      .cnt_o (xfer_cnt_o)
   );

   sat_counter #(.WIDTH(CntWidth)) u_stall_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (clear_i),
      .inc_i (stall),
      .cnt_o (stall_cnt_o)
   );

   // Stall-run length of the outstanding beat; not touched by clear_i.
   sat_counter #(.WIDTH(RunWidth)) u_run_cnt (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .clr_i (run_clr),
      .inc_i (run_inc),
      .cnt_o (run_cnt)
   );

endmodule

// File: tb/tb_stream_protocol_monitor.sv
// Bench for stream_protocol_monitor: two instances share one stimulus stream,
// instance a (16-bit counters, timeout 4) and instance b (2-bit counters,
// timeout disabled). A beat-level reference model predicts every output.
module tb_stream_protocol_monitor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       valid = 1'b0;
   logic       ready = 1'b0;
   logic       clear = 1'b0;
   logic [7:0] data = 8'h00;

   logic [15:0] a_xfer, a_stall;
   logic [7:0]  a_ldata;
   logic        a_lvld, a_hung, a_drop, a_chg, a_to;
   logic [1:0]  b_xfer, b_stall;
   logic [7:0]  b_ldata;
   logic        b_lvld, b_hung, b_drop, b_chg, b_to;

   always #5 clk = ~clk;

   stream_protocol_monitor #(.T(logic [7:0]), .CntWidth(16), .TimeoutCycles(4)) dut_a (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_i(ready), .data_i(data),
      .clear_i(clear), .xfer_cnt_o(a_xfer), .stall_cnt_o(a_stall),
      .last_data_o(a_ldata), .last_vld_o(a_lvld), .hung_o(a_hung),
      .err_drop_o(a_drop), .err_change_o(a_chg), .err_timeout_o(a_to)
   );

   stream_protocol_monitor #(.T(logic [7:0]), .CntWidth(2), .TimeoutCycles(0)) dut_b (
      .clk_i(clk), .rst_i(rst), .valid_i(valid), .ready_i(ready), .data_i(data),
      .clear_i(clear), .xfer_cnt_o(b_xfer), .stall_cnt_o(b_stall),
      .last_data_o(b_ldata), .last_vld_o(b_lvld), .hung_o(b_hung),
      .err_drop_o(b_drop), .err_change_o(b_chg), .err_timeout_o(b_to)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- reference model (beat level) ----------------
   int         tmo [2]  = '{4, 0};
   int         cmax[2]  = '{65535, 3};
   bit         m_out[2];      // a beat is outstanding
   bit         m_hung[2];
   int         m_run[2];      // stall cycles of the outstanding beat
   logic [7:0] m_pdata[2];
   int         m_xfer[2], m_stall[2];
   logic [7:0] m_ldata[2];
   bit         m_lvld[2], m_drop[2], m_chg[2], m_to[2];

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_out[k] = 0; m_hung[k] = 0; m_run[k] = 0; m_pdata[k] = 8'h00;
         m_xfer[k] = 0; m_stall[k] = 0; m_ldata[k] = 8'h00; m_lvld[k] = 0;
         m_drop[k] = 0; m_chg[k] = 0; m_to[k] = 0;
      end
   endtask

   task automatic model_step();
      bit hs, st, drop, chg, to;
      for (int k = 0; k < 2; k++) begin
         hs = valid && ready;
         st = valid && !ready;
         drop = 0; chg = 0; to = 0;
         if (!m_out[k]) begin
            if (st) begin
               m_out[k] = 1; m_pdata[k] = data; m_run[k] = 1;
               if (tmo[k] != 0 && m_run[k] >= tmo[k]) begin
                  m_hung[k] = 1; to = 1;
               end
            end
         end else if (!valid) begin
            drop = 1; m_out[k] = 0; m_hung[k] = 0; m_run[k] = 0;
         end else begin
            if (data != m_pdata[k]) chg = 1;
            if (ready) begin
               m_out[k] = 0; m_hung[k] = 0; m_run[k] = 0;
            end else begin
               m_run[k]++;
               if (tmo[k] != 0 && !m_hung[k] && m_run[k] >= tmo[k]) begin
                  m_hung[k] = 1; to = 1;
               end
            end
         end
         if (clear) begin
            m_xfer[k] = 0; m_stall[k] = 0; m_lvld[k] = 0;
            m_drop[k] = 0; m_chg[k] = 0; m_to[k] = 0;
         end else begin
            if (hs) begin
               if (m_xfer[k] < cmax[k]) m_xfer[k]++;
               m_ldata[k] = data;
               m_lvld[k] = 1;
            end
            if (st && m_stall[k] < cmax[k]) m_stall[k]++;
            m_drop[k] = m_drop[k] | drop;
            m_chg[k]  = m_chg[k] | chg;
            m_to[k]   = m_to[k] | to;
         end
      end
   endtask

   task automatic check_all(input string tag);
      check({tag, " a_xfer"},  32'(a_xfer),  32'(m_xfer[0]));
      check({tag, " a_stall"}, 32'(a_stall), 32'(m_stall[0]));
      check({tag, " a_ldata"}, 32'(a_ldata), 32'(m_ldata[0]));
      check({tag, " a_lvld"},  32'(a_lvld),  32'(m_lvld[0]));
      check({tag, " a_hung"},  32'(a_hung),  32'(m_hung[0]));
      check({tag, " a_drop"},  32'(a_drop),  32'(m_drop[0]));
      check({tag, " a_chg"},   32'(a_chg),   32'(m_chg[0]));
      check({tag, " a_to"},    32'(a_to),    32'(m_to[0]));
      check({tag, " b_xfer"},  32'(b_xfer),  32'(m_xfer[1]));
      check({tag, " b_stall"}, 32'(b_stall), 32'(m_stall[1]));
      check({tag, " b_ldata"}, 32'(b_ldata), 32'(m_ldata[1]));
      check({tag, " b_lvld"},  32'(b_lvld),  32'(m_lvld[1]));
      check({tag, " b_hung"},  32'(b_hung),  32'(m_hung[1]));
      check({tag, " b_drop"},  32'(b_drop),  32'(m_drop[1]));
      check({tag, " b_chg"},   32'(b_chg),   32'(m_chg[1]));
      check({tag, " b_to"},    32'(b_to),    32'(m_to[1]));
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive(input logic v, input logic r, input logic [7:0] d, input logic c);
      valid = v; ready = r; data = d; clear = c;
   endtask

   // One clock: inputs already applied; model follows the edge, outputs checked 1ns later.
   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   // Asynchronous reset asserted between edges; outputs must drop immediately.
   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   initial begin
      model_reset();
      #2;
      check_all("por");
      @(negedge clk);
      rst = 1'b0;

      // Back-to-back beats with ready tied high.
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 8'(i), 0);
         cycle("b2b");
      end
      drive(0, 1, 8'h00, 0);
      cycle("b2b_end");
      check("b2b a_xfer10", 32'(a_xfer), 32'd10);
      check("b2b b_xfer_sat", 32'(b_xfer), 32'd3);
      check("b2b a_stall0", 32'(a_stall), 32'd0);
      check("b2b a_ldata9", 32'(a_ldata), 32'd9);
      check("b2b a_errs", 32'({a_drop, a_chg, a_to, a_hung}), 32'd0);

      // Stalled beat accepted after three stall cycles.
      do_reset("rst_stall");
      drive(1, 0, 8'hA5, 0);
      for (int i = 0; i < 3; i++) cycle("stall");
      drive(1, 1, 8'hA5, 0);
      cycle("stall_hs");
      drive(0, 0, 8'h00, 0);
      cycle("stall_end");
      check("stall a_stall3", 32'(a_stall), 32'd3);
      check("stall a_xfer1", 32'(a_xfer), 32'd1);
      check("stall a_ldataA5", 32'(a_ldata), 32'hA5);
      check("stall a_errs", 32'({a_drop, a_chg, a_to}), 32'd0);

      // Valid dropped before acceptance.
      do_reset("rst_drop");
      drive(1, 0, 8'h11, 0);
      cycle("drop_v");
      drive(0, 0, 8'h11, 0);
      cycle("drop_x");
      check("drop a_drop1", 32'(a_drop), 32'd1);
      check("drop a_xfer0", 32'(a_xfer), 32'd0);
      cycle("drop_idle");

      // Payload changes while pending, then accepted.
      do_reset("rst_chg");
      drive(1, 0, 8'h11, 0);
      cycle("chg_p");
      drive(1, 0, 8'h22, 0);
      cycle("chg_c");
      check("chg a_chg1", 32'(a_chg), 32'd1);
      drive(1, 1, 8'h22, 0);
      cycle("chg_hs");
      drive(0, 0, 8'h00, 0);
      cycle("chg_end");
      check("chg a_xfer1", 32'(a_xfer), 32'd1);
      check("chg a_ldata22", 32'(a_ldata), 32'h22);

      // Timeout: hung after the 4th stall, released by handshake.
      do_reset("rst_to");
      drive(1, 0, 8'h33, 0);
      for (int i = 1; i <= 6; i++) begin
         cycle("to_stall");
         check("to a_hung", 32'(a_hung), (i >= 4) ? 32'd1 : 32'd0);
      end
      check("to a_to1", 32'(a_to), 32'd1);
      check("to b_hung0", 32'(b_hung), 32'd0);
      drive(1, 1, 8'h33, 0);
      cycle("to_hs");
      check("to a_hung_rel", 32'(a_hung), 32'd0);
      check("to a_to_sticky", 32'(a_to), 32'd1);
      drive(1, 1, 8'h44, 1);
      cycle("to_clr");
      check("to_clr a_to0", 32'(a_to), 32'd0);
      check("to_clr a_xfer0", 32'(a_xfer), 32'd0);
      drive(0, 0, 8'h00, 0);
      cycle("to_end");

      // Saturation and async reset in the middle of a pending beat.
      do_reset("rst_sat");
      for (int i = 0; i < 5; i++) begin
         drive(1, 1, 8'(8'h50 + i), 0);
         cycle("sat");
      end
      check("sat b_xfer3", 32'(b_xfer), 32'd3);
      check("sat a_xfer5", 32'(a_xfer), 32'd5);
      drive(1, 0, 8'h66, 0);
      cycle("mid_p1");
      cycle("mid_p2");
      do_reset("mid_rst");
      check("mid_rst a_outs", 32'({a_xfer, a_ldata, a_lvld, a_hung, a_drop, a_chg, a_to}), 32'd0);
      drive(0, 0, 8'h00, 0);
      cycle("mid_after");
      check("mid_after a_drop0", 32'(a_drop), 32'd0);

      // Randomized traffic, including protocol violations and clears.
      for (int i = 0; i < 600; i++) begin
         logic v, r, c;
         logic [7:0] d;
         v = ($urandom_range(0, 99) < 75);
         r = ($urandom_range(0, 99) < 45);
         c = ($urandom_range(0, 99) < 3);
         if (m_out[0] && $urandom_range(0, 99) < 90) d = m_pdata[0];
         else d = 8'($urandom_range(0, 255));
         drive(v, r, d, c);
         cycle("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
